// File: rtl/axi_master_rw.sv
// Single-outstanding AXI4 burst master: one command at a time becomes either an INCR write
// burst (AW + W + B) or an INCR read burst (AR + R). A one-cycle done pulse reports the outcome.
module axi_master_rw #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    // Command
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    // Write-data stream
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [STRB_WIDTH-1:0] wr_strb,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    // Read-data stream
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    // Completion
    output logic                  done_valid,
    output logic                  done_error,
    // AW channel
    output logic [ID_WIDTH-1:0]   m_axi_awid,
    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awlock,
    output logic [3:0]            m_axi_awcache,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    // W channel
    output logic [DATA_WIDTH-1:0] m_axi_wdata,
    output logic [STRB_WIDTH-1:0] m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    // B channel
    input  logic [ID_WIDTH-1:0]   m_axi_bid,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    // AR channel
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    // R channel
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam logic [2:0] BeatSize = 3'($clog2(STRB_WIDTH));

    typedef enum logic [1:0] {StIdle, StWrite, StWresp, StRead} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  awvalid_q, awvalid_d;
    logic                  arvalid_q, arvalid_d;
    logic                  aw_done_q, aw_done_d;  // AW accepted for the current burst
    logic                  w_done_q, w_done_d;    // last W beat sent, still waiting on AW
    logic                  err_q, err_d;          // sticky read error
    logic                  done_valid_q, done_valid_d;
    logic                  done_error_q, done_error_d;

    logic w_active, r_active;
    logic aw_hs, ar_hs, w_hs, r_hs;

    // IDs are never checked; one transaction is outstanding at a time.
    logic unused_in;
    assign unused_in = ^{m_axi_bid, m_axi_rid, m_axi_bresp[0], m_axi_rresp[0]};

    assign m_axi_awid    = '0;
    assign m_axi_awsize  = BeatSize;
    assign m_axi_awburst = 2'b01;
    assign m_axi_awlock  = 1'b0;
    assign m_axi_awcache = 4'b0011;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_arid    = '0;
    assign m_axi_arsize  = BeatSize;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'b0011;
    assign m_axi_arprot  = 3'b000;

    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = len_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arvalid = arvalid_q;

    assign cmd_ready = (state_q == StIdle);

    // W runs independently of AW; it goes quiet once the last beat is out.
    assign w_active     = (state_q == StWrite) && !w_done_q;
    assign m_axi_wvalid = w_active && wr_valid;
    assign wr_ready     = w_active && m_axi_wready;
    assign m_axi_wdata  = wr_data;
    assign m_axi_wstrb  = wr_strb;
    assign m_axi_wlast  = (state_q == StWrite) && (cnt_q == 8'd0);
    assign m_axi_bready = (state_q == StWresp);

    assign r_active     = (state_q == StRead);
    assign rd_valid     = r_active && m_axi_rvalid;
    assign m_axi_rready = r_active && rd_ready;
    assign rd_data      = m_axi_rdata;
    assign rd_last      = m_axi_rlast;

    assign done_valid = done_valid_q;
    assign done_error = done_error_q;

    assign aw_hs = awvalid_q && m_axi_awready;
    assign ar_hs = arvalid_q && m_axi_arready;
    assign w_hs  = m_axi_wvalid && m_axi_wready;
    assign r_hs  = m_axi_rvalid && m_axi_rready;

    // Next-state logic: FSM transitions, address/valid registers, beat counter and error tracking.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        awvalid_d    = awvalid_q;
        arvalid_d    = arvalid_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        err_d        = err_q;
        done_valid_d = 1'b0;
        done_error_d = done_error_q;

        if (aw_hs) awvalid_d = 1'b0;
        if (ar_hs) arvalid_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    len_d     = cmd_len;
                    cnt_d     = cmd_len;
                    err_d     = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (cmd_write) begin
                        awvalid_d = 1'b1;
                        state_d   = StWrite;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = StRead;
                    end
                end
            end
            StWrite: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs) begin
                    if (cnt_q == 8'd0) begin
                        if (aw_done_q || aw_hs) state_d = StWresp;
                        else                    w_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                if (w_done_q && aw_hs) state_d = StWresp;
            end
            StWresp: begin
                if (m_axi_bvalid) begin
                    state_d      = StIdle;
                    done_valid_d = 1'b1;
                    done_error_d = m_axi_bresp[1];
                end
            end
            StRead: begin
                if (r_hs) begin
                    err_d = err_q | m_axi_rresp[1];
                    if (cnt_q != 8'd0)     cnt_d = cnt_q - 8'd1;
                    else if (!m_axi_rlast) err_d = 1'b1;  // beat beyond the requested length
                    if (m_axi_rlast) begin
                        state_d      = StIdle;
                        done_valid_d = 1'b1;
                        done_error_d = err_q | m_axi_rresp[1] | (cnt_q != 8'd0);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset abandons any burst in flight without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            awvalid_q    <= 1'b0;
            arvalid_q    <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            err_q        <= 1'b0;
            done_valid_q <= 1'b0;
            done_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            awvalid_q    <= awvalid_d;
            arvalid_q    <= arvalid_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
            err_q        <= err_d;
            done_valid_q <= done_valid_d;
            done_error_q <= done_error_d;
        end
    end

endmodule

// File: doc/axi_master_rw.md
AXI_MASTER_RW -- requirements
Module: axi_master_rw

Interface
REQ-001 Parameter DATA_WIDTH, default 32: AXI and user data width in bits.
REQ-002 Parameter ADDR_WIDTH, default 16: byte address width.
REQ-003 Parameter STRB_WIDTH, default DATA_WIDTH/8: byte lanes per beat.
REQ-004 Parameter ID_WIDTH, default 8: AXI ID width.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-008 cmd_write  in  1  1 = write burst, 0 = read burst.
REQ-009 cmd_addr  in  ADDR_WIDTH  burst start byte address.
REQ-010 cmd_len  in  8  beats minus one (0..255).
REQ-011 wr_data/wr_strb/wr_valid/wr_ready  in/in/in/out  DATA_WIDTH/STRB_WIDTH/1/1  write-data stream.
REQ-012 rd_data/rd_last/rd_valid/rd_ready  out/out/out/in  DATA_WIDTH/1/1/1  read-data stream.
REQ-013 done_valid/done_error  out  1/1  one-cycle completion pulse and error flag.
REQ-014 m_axi_awaddr/awlen/awvalid/awready  out/out/out/in  ADDR_WIDTH/8/1/1  AW channel.
REQ-015 m_axi_wdata/wstrb/wlast/wvalid/wready  out/out/out/out/in  DATA_WIDTH/STRB_WIDTH/1/1/1  W channel.
REQ-016 m_axi_bresp/bvalid/bready  in/in/out  2/1/1  B channel; m_axi_bid input ignored.
REQ-017 m_axi_araddr/arlen/arvalid/arready  out/out/out/in  ADDR_WIDTH/8/1/1  AR channel.
REQ-018 m_axi_rdata/rresp/rlast/rvalid/rready  in/in/in/in/out  DATA_WIDTH/2/1/1/1  R channel; m_axi_rid input ignored.
REQ-019 Constant outputs: awid/arid = 0, awsize/arsize = $clog2(STRB_WIDTH), awburst/arburst = 2'b01 (INCR), awlock/arlock = 0, awcache/arcache = 4'b0011, awprot/arprot = 0.

Function
REQ-020 States: IDLE, WRITE, WRESP, READ; one transaction outstanding at a time.
REQ-021 cmd_ready = 1 only in IDLE; accept on cmd_valid && cmd_ready; latch addr, len, and beat counter = cmd_len.
REQ-022 Write accept -> WRITE next cycle with registered m_axi_awvalid = 1, awaddr = cmd_addr, awlen = cmd_len; awvalid drops the cycle after awready && awvalid and stays low for the rest of the burst.
REQ-023 In WRITE: m_axi_wvalid = wr_valid, wr_ready = m_axi_wready, wdata/wstrb pass through combinationally; wlast = (counter == 0); counter decrements per W handshake; W beats are not gated by AW acceptance.
REQ-024 WRITE -> WRESP when the last W beat handshakes and AW has been accepted (same or earlier cycle); otherwise wait for AW with W idle.
REQ-025 In WRESP: m_axi_bready = 1; on bvalid -> IDLE, done_valid = 1 for one cycle, done_error = bresp[1].
REQ-026 Read accept -> READ next cycle with registered m_axi_arvalid = 1, araddr, arlen; arvalid drops after handshake.
REQ-027 In READ: rd_valid = m_axi_rvalid, m_axi_rready = rd_ready, rd_data = m_axi_rdata, rd_last = m_axi_rlast; counter decrements per R handshake; sticky error |= rresp[1].
REQ-028 R handshake with m_axi_rlast = 1 -> IDLE, done_valid pulse, done_error = sticky error OR (counter != 0); R beats after counter reaches 0 without rlast also set the sticky error.
REQ-029 Outside WRITE/WRESP/READ: wr_ready, m_axi_wvalid, m_axi_bready, m_axi_rready and rd_valid = 0.
REQ-030 No 4 KB boundary check; the caller guarantees legal bursts.
REQ-031 done_valid is a pulse; it does not wait for a ready signal.

Reset
REQ-032 rst asserted: state = IDLE, awvalid = arvalid = 0, done_valid = 0, sticky error = 0, counter = 0, effective immediately (asynchronous).
REQ-033 Reset mid-burst abandons the transaction with no done pulse; cmd_ready = 1 on the first clock edge after rst deasserts.

Verification
REQ-034 Write, addr 0x0100, len 3, AXI RAM slave, wr_valid always high -> 4 W beats, wlast on beat 4 only, one done_valid, done_error = 0, RAM words 0x40..0x43 updated.
REQ-035 Read, addr 0x0100, len 3, rd_ready toggling 1/0 -> 4 rd beats matching written data, rd_last on beat 4, done_error = 0.
REQ-036 Single-beat write with awready delayed 5 cycles after wready -> wlast on beat 1, WRESP entered only after AW handshake, one done pulse.
REQ-037 Slave returns bresp = 2'b10 -> done_error = 1. Read with rresp = 2'b11 on beat 2 of 4 -> done_error = 1.
REQ-038 rst pulsed during beat 2 of an 8-beat read -> awvalid = arvalid = rready = 0 at once, no done pulse, next command accepted normally.
